// File: rtl/calc_arb_pkg.sv
// ---------------------------------------------------------------------------
// calc_arb_pkg
//   Shared definitions for the calculator command arbiter:
//   - default values for the arbiter parameters
//   - FSM state encoding (also exported on the top-level debug port)
//   - small helper to turn a requester index into a one-hot pulse vector
// ---------------------------------------------------------------------------
package calc_arb_pkg;

   localparam int DEF_INBITS  = 8;   // operand width per requester
   localparam int DEF_WIDTH   = 8;   // address width
   localparam int DEF_DIV_CFG = 3;   // clock divider written after reset
   localparam int DEF_TIMEOUT = 16;  // cycles allowed for CalcBusy to rise

   typedef enum logic [2:0] {
      CONFIG    = 3'd0,
      IDLE      = 3'd1,
      ISSUE     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } arb_state_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. A lone requester always wins; on a tie the
//   requester that was not granted last wins. The history pointer moves only
//   when 'advance' is high and some request is present.
//
//   Clk      in   clock
//   Reset    in   asynchronous active-low reset (pointer -> "requester 1 last")
//   req      in   [1:0] request vector
//   advance  in   accept the current grant and update the pointer
//   gnt      out  [1:0] one-hot grant (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // 1: requester 1 received the most recent grant
   logic last1;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last1 ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         last1 <= 1'b1;
      end else if (advance && (req != 2'b00)) begin
         last1 <= gnt[1];
      end
   end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// calc_cmd_arbiter
//   Arbitrates two command requesters onto a single calculator port. After
//   reset the calculator clock divider is written once (ConfigDiv pulse).
//   Then each accepted command is issued for one cycle (ValidCmd); writes
//   complete immediately, reads wait for CalcBusy to rise (bounded by
//   TIMEOUT) and then fall.
//
//   Handshake: a requester raises Req[n] with its fields stable and holds
//   them until it sees Gnt[n]; Gnt[n] is a one-cycle pulse in the cycle the
//   command is on the calculator bus (ValidCmd), after which Req[n] may drop.
//   Completion is a one-cycle Done[n] pulse, or Err[n] if a read timed out.
//
//   Clk        in   clock
//   Reset      in   asynchronous active-low reset
//   Req        in   [1:0] per-requester request level
//   ReqRW      in   [1:0] per-requester 1 = write, 0 = read/calculate
//   ReqSel     in   [7:0] 4-bit Sel per requester
//   ReqInA/B   in   [2*INBITS-1:0] operands per requester
//   ReqAddr    in   [2*WIDTH-1:0] address per requester
//   Gnt        out  [1:0] accept pulse
//   Done       out  [1:0] completion pulse
//   Err        out  [1:0] read timeout pulse
//   ValidCmd, RW, ConfigDiv, InputKey  out  calculator controls
//   InA, InB, Addr, Sel, Din           out  calculator command fields
//   CalcBusy   in   calculator busy status
//   DbgState   out  [2:0] current FSM state (arb_state_t encoding)
// ---------------------------------------------------------------------------
module calc_cmd_arbiter
   import calc_arb_pkg::*;
#(
   parameter int INBITS  = DEF_INBITS,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DIV_CFG = DEF_DIV_CFG,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [1:0]          Req,
   input  logic [1:0]          ReqRW,
   input  logic [7:0]          ReqSel,
   input  logic [2*INBITS-1:0] ReqInA,
   input  logic [2*INBITS-1:0] ReqInB,
   input  logic [2*WIDTH-1:0]  ReqAddr,
   output logic [1:0]          Gnt,
   output logic [1:0]          Done,
   output logic [1:0]          Err,
   output logic                ValidCmd,
   output logic                RW,
   output logic                ConfigDiv,
   output logic                InputKey,
   output logic [INBITS-1:0]   InA,
   output logic [INBITS-1:0]   InB,
   output logic [WIDTH-1:0]    Addr,
   output logic [3:0]          Sel,
   output logic [31:0]         Din,
   input  logic                CalcBusy,
   output logic [2:0]          DbgState
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // The counter reads k at the end of the k-th cycle after ISSUE, so a
   // match on TIMEOUT-1 makes Err appear exactly TIMEOUT cycles after ISSUE.
   localparam logic [CNT_W-1:0] TCNT_MAX = CNT_W'(TIMEOUT - 1);

   arb_state_t       state;
   logic [1:0]       win_gnt;
   logic             win;
   logic             take;
   logic             cur;     // index of the requester being served
   logic [CNT_W-1:0] tcnt;

   assign take     = (state == IDLE) && (Req != 2'b00);
   assign win      = win_gnt[1];
   assign InputKey = 1'b0;
   assign DbgState = state;

   rr_arbiter2 u_rr (
      .Clk     (Clk),
      .Reset   (Reset),
      .req     (Req),
      .advance (take),
      .gnt     (win_gnt)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= CONFIG;
         cur       <= 1'b0;
         tcnt      <= '0;
         Gnt       <= 2'b00;
         Done      <= 2'b00;
         Err       <= 2'b00;
         ValidCmd  <= 1'b0;
         ConfigDiv <= 1'b0;
         RW        <= 1'b0;
         InA       <= '0;
         InB       <= '0;
         Addr      <= '0;
         Sel       <= '0;
         Din       <= '0;
      end else begin
         // pulse outputs default low every cycle
         Gnt       <= 2'b00;
         Done      <= 2'b00;
         Err       <= 2'b00;
         ValidCmd  <= 1'b0;
         ConfigDiv <= 1'b0;

         case (state)
            CONFIG: begin
               // first cycle out of reset raises ConfigDiv, the next leaves
               if (ConfigDiv) begin
                  state <= IDLE;
               end else begin
                  ConfigDiv <= 1'b1;
                  Din       <= 32'(DIV_CFG);
               end
            end

            IDLE: begin
               if (take) begin
                  cur      <= win;
                  Gnt      <= win_gnt;
                  ValidCmd <= 1'b1;
                  RW       <= win ? ReqRW[1] : ReqRW[0];
                  Sel      <= win ? ReqSel[7:4] : ReqSel[3:0];
                  InA      <= win ? ReqInA[2*INBITS-1:INBITS] : ReqInA[INBITS-1:0];
                  InB      <= win ? ReqInB[2*INBITS-1:INBITS] : ReqInB[INBITS-1:0];
                  Addr     <= win ? ReqAddr[2*WIDTH-1:WIDTH] : ReqAddr[WIDTH-1:0];
                  tcnt     <= '0;
                  state    <= ISSUE;
               end
            end

            ISSUE: begin
               tcnt <= tcnt + 1'b1;
               if (RW) begin
                  Done  <= onehot2(cur);
                  state <= IDLE;
               end else begin
                  state <= WAIT_BUSY;
               end
            end

            WAIT_BUSY: begin
               // a busy rise on the last allowed cycle still wins over timeout
               if (CalcBusy) begin
                  state <= WAIT_DONE;
               end else if (tcnt == TCNT_MAX) begin
                  Err   <= onehot2(cur);
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            WAIT_DONE: begin
               if (!CalcBusy) begin
                  Done  <= onehot2(cur);
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
